udma_filter_tx_chan_arbiter: RTL

UDMA_FILTER_TX_CHAN_ARBITER -- requirements
Module: udma_filter_tx_chan_arbiter

---
 rtl/udma_filter_pkg.sv | 19 +
 rtl/udma_filter_id_fifo.sv | 55 +++++
 rtl/udma_filter_tx_chan_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/udma_filter_pkg.sv
// Shared udma filter constants: datasize encodings, mode codes and small sizing helpers.
// No logic, no latency, no flow control of its own.
package udma_filter_pkg;

    typedef enum logic [1:0] {
        DSIZE_BYTE = 2'b00,
        DSIZE_HALF = 2'b01,
        DSIZE_WORD = 2'b10
    } dsize_e;

    localparam logic [1:0] MODE_LIN    = 2'b00;
    localparam logic [1:0] MODE_2D_ROW = 2'b01;
    localparam logic [1:0] MODE_2D_COL = 2'b10;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udma_filter_id_fifo.sv
// In-order FIFO of requester IDs for reads in flight; zero read latency (head is combinational).
// Push is ignored when full and pop when empty; the caller gates both.
module udma_filter_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/udma_filter_tx_chan_arbiter.sv
// Round-robin arbiter of datafetch readers onto one L2 TX channel, responses routed back in issue order.
// Zero added latency; L2 request drops at MAX_OUTSTANDING in flight, response ready follows the head requester.
module udma_filter_tx_chan_arbiter
    import udma_filter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int L2_AWIDTH_NOAL  = 15,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                    clk_i,
    input  logic                                    resetn_i,
    input  logic [NUM_REQ-1:0]                      req_i,
    input  logic [NUM_REQ-1:0][L2_AWIDTH_NOAL-1:0]  addr_i,
    input  logic [NUM_REQ-1:0][1:0]                 datasize_i,
    output logic [NUM_REQ-1:0]                      gnt_o,
    output logic [NUM_REQ-1:0]                      valid_o,
    output logic [DATA_WIDTH-1:0]                   data_o,
    input  logic [NUM_REQ-1:0]                      ready_i,
    output logic                                    tx_ch_req_o,
    output logic [L2_AWIDTH_NOAL-1:0]               tx_ch_addr_o,
    output logic [1:0]                              tx_ch_datasize_o,
    input  logic                                    tx_ch_gnt_i,
    input  logic                                    tx_ch_valid_i,
    input  logic [DATA_WIDTH-1:0]                   tx_ch_data_i,
    output logic                                    tx_ch_ready_o,
    output logic                                    err_o
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [ID_W-1:0]  r_prio;
    logic [ID_W-1:0]  winner;
    logic [ID_W:0]    cand;
    logic             req_any;
    logic             accept;
    logic             pop;
    logic             err_q;
    logic [ID_W-1:0]  fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] r_count;

    // Scan requesters starting at r_prio, wrapping modulo NUM_REQ; first asserted wins.
    always_comb begin
        winner  = '0;
        req_any = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, r_prio} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
            if (!req_any && req_i[cand[ID_W-1:0]]) begin
                req_any = 1'b1;
                winner  = cand[ID_W-1:0];
            end
        end
    end

    assign tx_ch_req_o      = resetn_i && req_any && !fifo_full && (r_count < CNT_W'(MAX_OUTSTANDING));
    assign tx_ch_addr_o     = resetn_i ? addr_i[winner] : '0;
    assign tx_ch_datasize_o = resetn_i ? datasize_i[winner] : 2'b00;
    assign accept           = tx_ch_req_o && tx_ch_gnt_i;

    // No bypass: a response arriving while nothing is outstanding is never acknowledged.
    assign tx_ch_ready_o = resetn_i && !fifo_empty && ready_i[fifo_head];
    assign pop           = tx_ch_valid_i && tx_ch_ready_o;
    assign data_o        = resetn_i ? tx_ch_data_i : '0;
    assign err_o         = resetn_i && err_q;

    always_comb begin
        gnt_o   = '0;
        valid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i]   = accept && (winner == ID_W'(i));
            valid_o[i] = resetn_i && tx_ch_valid_i && !fifo_empty && (fifo_head == ID_W'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_prio <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) r_prio <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            if (tx_ch_valid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    udma_filter_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push     (accept),
        .push_id  (winner),
        .pop      (pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (r_count)
    );

endmodule
